npu_input_fifo: RTL
===================

# npu_input_fifo

Parametrised multi-row input buffer for the NPU datapath, the successor to the single-row 8-lane latch. It stores up to DEPTH activation vectors of LANES × DATA_W bits in a FIFO and releases one vector per pop into a registered output stage. It sits between the host-load path and the PE array. Optional per-lane diagonal skew lets it feed a systolic array directly.

## Interface
- DATA_W, 8, bits per lane element
- LANES, 8, lanes per vector; lane k occupies bits [k*DATA_W +: DATA_W]
- DEPTH, 4, vectors stored; power of two, ≥2
- CLKEXT  in  1  single clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- CLR_BUF_IN  in  1  synchronous clear; highest synchronous priority
- EN_BUF_IN  in  1  push request; writes IN_VEC
- IN_VEC  in  LANES*DATA_W  vector to push
- RD_BUF_IN  in  1  pop request
- FULL  out  1  COUNT == DEPTH
- EMPTY  out  1  COUNT == 0
- COUNT  out  $clog2(DEPTH+1)  vectors held
- OUT_VEC  out  LANES*DATA_W  popped vector, possibly skewed per lane
- OUT_VALID  out  LANES  per-lane valid strobe for OUT_VEC

## Operation
- Storage: DEPTH-entry register array. Write and read pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. COUNT is tracked separately, so full and empty are unambiguous.
- Push accepted = EN_BUF_IN & (!FULL | pop accepted). The entry at the write pointer is written and the pointer increments.
- Pop accepted = RD_BUF_IN & !EMPTY. The head entry is loaded into the output register, the read pointer increments, and the base valid is 1 for one cycle.
- COUNT += push − pop. Simultaneous push and pop leaves COUNT unchanged.
- Push when FULL with no pop: dropped silently. Storage, pointers and COUNT are unchanged.
- Pop when EMPTY: ignored. Base valid is 0 and the output register holds its value.
- Simultaneous push and pop when EMPTY: the push is stored and the pop is ignored. There is no bypass, so the data is available for a pop next cycle.
- When no pop is accepted, the output register holds its last value. Valid is a one-cycle strobe per pop.
- CLR_BUF_IN=1: pointers, COUNT, output register, skew registers and valids are zeroed. Same-cycle push and pop are discarded. Storage array contents are don't-care.
- RST=1: same state as CLR, applied asynchronously.

## Timing
- Reset values: FULL=0, EMPTY=1, COUNT=0, OUT_VEC=0, OUT_VALID=0.
- FULL, EMPTY and COUNT are registered and reflect the cycle after the push or pop edge.
- Pop latency without skew: pop sampled at edge N, then OUT_VEC and OUT_VALID (all bits) are valid after edge N.
- Back-to-back pops on consecutive cycles deliver consecutive vectors with no bubbles. Throughput is 1 vector per cycle.
- Push-to-pop: data pushed at edge N can be popped at edge N+1 at the earliest.

## Configuration
- INPUT_FIFO_SKEW_EN defined:
  - Lane k of OUT_VEC and OUT_VALID[k] pass through k extra registers after the output register.
  - So lane k of a vector popped at edge N appears after edge N+k.
  - Skew registers shift every cycle unconditionally and are cleared by RST and CLR.
  - Lane 0 timing is identical to the unskewed build.
- Not defined: no skew registers exist. All OUT_VALID bits are equal and all lanes of OUT_VEC update together.

## Test plan
- Reset and basic order (DEPTH=4, LANES=8): assert RST mid-cycle, then push lane-index vectors 0x11..0x18, 0x21..0x28 and pop twice.
  - Required: the two vectors come out in order on consecutive cycles.
  - Required: OUT_VALID=0xFF for exactly one cycle each.
  - Required: COUNT sequence is 0,1,2,1,0.
- Full and wrap: push 5 vectors A–E with no pop.
  - Required: FULL after the 4th push and COUNT=4.
  - Required: E dropped.
  - Then pop 4 and push 2 more: order is A,B,C,D, then the new vectors, showing pointer wrap.
- Simultaneous events:
  - When FULL, push and pop together: COUNT stays 4, FULL stays 1, the head is popped and the new vector is queued at the tail.
  - When EMPTY, push and pop together: OUT_VALID=0 and COUNT becomes 1.
- Clear mid-operation: with COUNT=3, assert CLR_BUF_IN together with push and pop.
  - Required next cycle: COUNT=0, EMPTY=1, OUT_VEC=0, OUT_VALID=0.
  - Required: a subsequent pop returns nothing.
- Empty pop: pop when EMPTY. Required: OUT_VALID=0 and OUT_VEC holds its previous value.
- Skew (macro defined, LANES=8): pop vector 0x0807060504030201 at edge N. Required: lane k shows value k+1 with OUT_VALID[k]=1 exactly at edge N+k.

Source files
------------

// File: rtl/npu_input_fifo.sv
// npu_input_fifo: DEPTH-deep vector FIFO with registered output; INPUT_FIFO_SKEW_EN adds per-lane diagonal skew
module npu_input_fifo #(
    parameter int DATA_W = 8,
    parameter int LANES = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int VW = LANES * DATA_W
) (
    input  logic          CLKEXT,
    input  logic          RST,
    input  logic          CLR_BUF_IN,
    input  logic          EN_BUF_IN,
    input  logic [VW-1:0] IN_VEC,
    input  logic          RD_BUF_IN,
    output logic          FULL,
    output logic          EMPTY,
    output logic [CW-1:0] COUNT,
    output logic [VW-1:0] OUT_VEC,
    output logic [LANES-1:0] OUT_VALID
);
    logic [VW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_n;
    logic full_q, empty_q, v_q, pop, push;
    logic [VW-1:0] out_q;
    assign pop = RD_BUF_IN & ~empty_q;
    assign push = EN_BUF_IN & (~full_q | pop);
    assign count_n = count + CW'(push) - CW'(pop);
    assign FULL = full_q;
    assign EMPTY = empty_q;
    assign COUNT = count;
    always_ff @(posedge CLKEXT)
        if (push && !CLR_BUF_IN) mem[wr_ptr] <= IN_VEC;
    always_ff @(posedge CLKEXT or posedge RST)
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
            out_q <= '0;
            v_q <= 1'b0;
        end else if (CLR_BUF_IN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full_q <= 1'b0;
            empty_q <= 1'b1;
            out_q <= '0;
            v_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                out_q <= mem[rd_ptr];
            end
            v_q <= pop;
            count <= count_n;
            full_q <= count_n == CW'(DEPTH);
            empty_q <= count_n == '0;
        end
`ifdef INPUT_FIFO_SKEW_EN
    assign OUT_VEC[DATA_W-1:0] = out_q[DATA_W-1:0];
    assign OUT_VALID[0] = v_q;
    // lane k runs through a k-stage delay line so lanes leave on a diagonal
    for (genvar k = 1; k < LANES; k++) begin : g_skew
        localparam int K = k;
        localparam int W = k * DATA_W;
        logic [W-1:0] d;
        logic [K-1:0] v;
        always_ff @(posedge CLKEXT or posedge RST)
            if (RST) begin
                d <= '0;
                v <= '0;
            end else if (CLR_BUF_IN) begin
                d <= '0;
                v <= '0;
            end else begin
                d <= W'({d, out_q[k*DATA_W +: DATA_W]});
                v <= K'({v, v_q});
            end
        assign OUT_VEC[k*DATA_W +: DATA_W] = d[W-1 -: DATA_W];
        assign OUT_VALID[k] = v[K-1];
    end
`else
    assign OUT_VEC = out_q;
    assign OUT_VALID = {LANES{v_q}};
`endif
endmodule
